// File: rtl/logic_unit_pkg.sv
// Shared types for the two-port bitwise logic unit arbiter: opcodes, FSM
// encoding and the default datapath width.
package logic_unit_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational WIDTH-bit AND/OR/XOR/NOT mux; the OR path uses the existing
// 8-bit gate array when the width matches.
module logic_op_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] or_y;

  generate
    if (WIDTH == 8) begin : g_or8
      or_gate_8bit u_or (
        .a(a),
        .b(b),
        .y(or_y)
      );
    end else begin : g_or_generic
      assign or_y = a | b;
    end
  endgenerate

  // NOT ignores b entirely and inverts all WIDTH bits of a.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = or_y;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/or_gate_8bit.sv
// Existing 8-bit OR gate array from the bitwise gate datapath.
module or_gate_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  assign y = a | b;

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin sharing of one bitwise logic unit between two requesters,
// sequenced IDLE -> EXEC -> RESP with a registered valid/ready response.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_id,
  output logic             rsp_zero,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_EXEC = ST_EXEC;
  localparam logic [1:0] S_RESP = ST_RESP;

  logic [1:0]       state;
  logic             last_grant;
  logic             grant;
  logic             accept;
  op_e              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic [WIDTH-1:0] unit_y;

  // On a tie the requester that did not win last time gets the unit.
  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  assign req_ready = (!rst && state == S_IDLE) ?
                     (req_valid & (grant ? 2'b10 : 2'b01)) : 2'b00;
  assign accept    = |req_ready;
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

  logic_op_unit #(.WIDTH(WIDTH)) u_op (
    .op(op_q),
    .a (a_q),
    .b (b_q),
    .y (unit_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      op_q       <= OP_AND;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_y      <= '0;
      rsp_id     <= 1'b0;
      rsp_zero   <= 1'b0;
      done_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= grant ? op_e'(req_op1) : op_e'(req_op0);
            a_q   <= grant ? req_a1 : req_a0;
            b_q   <= grant ? req_b1 : req_b0;
            id_q  <= grant;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_y    <= unit_y;
          rsp_zero <= (unit_y == '0);
          rsp_id   <= id_q;
          state    <= S_RESP;
        end
        S_RESP: begin
          // Response fields stay frozen until the consumer takes them.
          if (rsp_ready) begin
            last_grant <= rsp_id;
            done_cnt   <= done_cnt + CNT_W'(1);
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter; a second instance with a 2-bit
// counter shares the stimulus so the done_cnt wrap can be observed.
module tb_logic_unit_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_op0;
  logic [1:0] req_op1;
  logic [7:0] req_a0;
  logic [7:0] req_b0;
  logic [7:0] req_a1;
  logic [7:0] req_b1;
  logic       rsp_ready;

  logic [1:0]  req_ready,  w_req_ready;
  logic        rsp_valid,  w_rsp_valid;
  logic [7:0]  rsp_y,      w_rsp_y;
  logic        rsp_id,     w_rsp_id;
  logic        rsp_zero,   w_rsp_zero;
  logic        busy,       w_busy;
  logic [15:0] done_cnt;
  logic [1:0]  w_done_cnt;

  int checks = 0;
  int errors = 0;

  logic_unit_arbiter #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_id(rsp_id), .rsp_zero(rsp_zero), .busy(busy), .done_cnt(done_cnt)
  );

  logic_unit_arbiter #(.WIDTH(8), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(w_req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_y(w_rsp_y),
    .rsp_id(w_rsp_id), .rsp_zero(w_rsp_zero), .busy(w_busy),
    .done_cnt(w_done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [1:0] op0, input logic [7:0] a0,
                               input logic [7:0] b0,
                               input logic [1:0] op1, input logic [7:0] a1,
                               input logic [7:0] b1, input logic rdy);
    req_valid = valid;
    req_op0   = op0;
    req_a0    = a0;
    req_b0    = b0;
    req_op1   = op1;
    req_a1    = a1;
    req_b1    = b1;
    rsp_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [7:0] exp_y;
    logic       exp_id;

    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0);
    step();
    step();
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_y", rsp_y, 0);
    checkOutput("rst_rsp_id", rsp_id, 0);
    checkOutput("rst_rsp_zero", rsp_zero, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done_cnt", done_cnt, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_w_outputs",
                {w_req_ready, w_rsp_valid, w_rsp_id, w_rsp_zero, w_busy, w_done_cnt}, 0);
    rst = 1'b0;

    $display("[TB] single OR request from requester 0");
    applyStimulus(2'b01, 2'b01, 8'hAA, 8'h55, 2'b00, 8'h00, 8'h00, 1'b1);
    checkOutput("or_req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    #1;
    checkOutput("or_exec_busy", busy, 1);
    checkOutput("or_exec_valid", rsp_valid, 0);
    step();
    checkOutput("or_rsp_valid", rsp_valid, 1);
    checkOutput("or_rsp_y", rsp_y, 8'hFF);
    checkOutput("or_rsp_id", rsp_id, 0);
    checkOutput("or_rsp_zero", rsp_zero, 0);
    step();
    checkOutput("or_done_cnt", done_cnt, 1);
    checkOutput("or_idle_valid", rsp_valid, 0);

    $display("[TB] single AND request from requester 1");
    applyStimulus(2'b10, 2'b00, 8'h00, 8'h00, 2'b00, 8'hAA, 8'h55, 1'b1);
    checkOutput("and_req_ready", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    step();
    checkOutput("and_rsp_y", rsp_y, 8'h00);
    checkOutput("and_rsp_zero", rsp_zero, 1);
    checkOutput("and_rsp_id", rsp_id, 1);
    step();
    checkOutput("and_done_cnt", done_cnt, 2);

    $display("[TB] continuous tie: alternating grants and counter wrap");
    rst = 1'b1;
    step();
    rst = 1'b0;
    applyStimulus(2'b11, 2'b11, 8'h0F, 8'h00, 2'b10, 8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      exp_id = i[0];
      exp_y  = exp_id ? 8'h00 : 8'hF0;
      checkOutput($sformatf("tie%0d_req_ready", i), req_ready,
                  exp_id ? 2'b10 : 2'b01);
      step();
      step();
      checkOutput($sformatf("tie%0d_rsp_id", i), rsp_id, exp_id);
      checkOutput($sformatf("tie%0d_rsp_y", i), rsp_y, exp_y);
      checkOutput($sformatf("tie%0d_w_rsp_y", i), w_rsp_y, exp_y);
      checkOutput($sformatf("tie%0d_w_rsp_id", i), w_rsp_id, exp_id);
      step();
      checkOutput($sformatf("tie%0d_done_cnt", i), done_cnt, i + 1);
      checkOutput($sformatf("tie%0d_w_done_cnt", i), w_done_cnt, (i + 1) % 4);
    end

    $display("[TB] response backpressure");
    applyStimulus(2'b01, 2'b01, 8'hAA, 8'h55, 2'b00, 8'h3C, 8'h0F, 1'b0);
    checkOutput("bp_req_ready", req_ready, 2'b01);
    step();
    step();
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp%0d_valid", i), rsp_valid, 1);
      checkOutput($sformatf("bp%0d_rsp_y", i), rsp_y, 8'hFF);
      checkOutput($sformatf("bp%0d_rsp_id", i), rsp_id, 0);
      checkOutput($sformatf("bp%0d_req_ready", i), req_ready, 2'b00);
      checkOutput($sformatf("bp%0d_busy", i), busy, 1);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_release_req_ready", req_ready, 2'b00);
    step();
    checkOutput("bp_next_req_ready", req_ready, 2'b10);
    checkOutput("bp_done_cnt", done_cnt, 6);

    $display("[TB] reset during EXEC");
    step();
    checkOutput("rst_exec_busy", busy, 1);
    rst = 1'b1;
    step();
    checkOutput("rstx_rsp_valid", rsp_valid, 0);
    checkOutput("rstx_rsp_y", rsp_y, 0);
    checkOutput("rstx_busy", busy, 0);
    checkOutput("rstx_done_cnt", done_cnt, 0);
    checkOutput("rstx_req_ready", req_ready, 2'b00);
    checkOutput("rstx_w_rsp_zero", w_rsp_zero, 0);
    rst = 1'b0;
    req_valid = 2'b00;
    step();
    step();
    checkOutput("rstx_no_response", rsp_valid, 0);
    req_valid = 2'b11;
    #1;
    checkOutput("rstx_tie_grant", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    step();
    checkOutput("rstx_after_rsp_id", rsp_id, 0);
    checkOutput("rstx_after_rsp_y", rsp_y, 8'hFF);
    step();
    checkOutput("rstx_after_done_cnt", done_cnt, 1);
    checkOutput("rstx_w_flags", {w_rsp_valid, w_busy, w_req_ready}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOT) between two requesters. A round-robin arbiter grants one requester at a time. A three-state FSM sequences the grant: operand capture, execution, and a registered result returned over a valid/ready response channel. The block sits between the register-file/control front end and the existing bitwise gate datapath, so that a single gate array serves both issue ports.

## Interface
- WIDTH, 8, operand/result width in bits
- CNT_W, 16, width of completed-operation counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; at most one bit high
- req_op0, req_op1  in  2 each  opcode: 00 AND, 01 OR, 10 XOR, 11 NOT a (b ignored)
- req_a0, req_b0, req_a1, req_b1  in  WIDTH each  operands
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_y  out  WIDTH  result
- rsp_id  out  1  index of requester that issued the result
- rsp_zero  out  1  high when rsp_y == 0
- busy  out  1  high in EXEC or RESP
- done_cnt  out  CNT_W  completed responses, wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Grant selection: if exactly one req_valid bit is set, that requester is granted. If both are set, the requester not equal to last_grant is granted.
  - req_ready[g] is combinational, asserted only in IDLE, and only for the granted g.
  - On handshake (req_valid[g] & req_ready[g]): latch op, a, b and g; go to EXEC.
- EXEC: one cycle. The shared logic unit computes from the latched operands. Result, zero flag and id are registered; go to RESP.
- RESP:
  - rsp_valid = 1; rsp_y, rsp_id and rsp_zero are held stable until rsp_ready.
  - On rsp_ready: set last_grant <= rsp_id, increment done_cnt, go to IDLE.
- NOT op: y = ~a over the full WIDTH bits; b is ignored.
- Arithmetic:
  - No carries.
  - Results are exactly WIDTH bits.
  - done_cnt wraps from all-ones to 0 with no flag.
- Reset values:
  - FSM = IDLE, last_grant = 1 (so requester 0 wins the first tie).
  - rsp_valid, rsp_y, rsp_id, rsp_zero, busy, done_cnt, req_ready all 0.
- Reset mid-operation: any in-flight transaction is dropped without a response. Counter and grant history are cleared.
- Requests arriving while busy are not accepted; req_ready stays 0 and the requester must hold its request.
- Requests are not queued.
- A requester whose req_valid drops before grant loses nothing.

## Timing
- Accept in cycle N; rsp_valid rises in cycle N+2.
- Minimum issue interval is 3 cycles: accept, EXEC, RESP with rsp_ready=1, then the next accept is possible in the following IDLE cycle.
- Backpressure: each cycle with rsp_ready=0 in RESP adds one cycle. Outputs are frozen during that time.
- The updated last_grant is visible to the next IDLE arbitration cycle.
- All outputs are registered except req_ready, which is combinational from state and req_valid.

## Structure
- Package logic_unit_pkg:
  - opcode enum: OP_AND, OP_OR, OP_XOR, OP_NOT.
  - FSM state enum: ST_IDLE, ST_EXEC, ST_RESP.
  - Default WIDTH constant.
- One sub-module, logic_op_unit: combinational WIDTH-bit op mux over AND/OR/XOR/NOT. The OR path reuses or_gate_8bit when WIDTH == 8.
- The arbiter, FSM and counter live in the top module.

## Test plan
- Single request from req 0, op=OR, a=10101010, b=01010101, rsp_ready=1:
  - rsp_y=11111111, rsp_id=0, rsp_zero=0, rsp_valid 2 cycles after accept.
  - done_cnt=1.
- req 1 only, op=AND, a=10101010, b=01010101 -> rsp_y=00000000, rsp_zero=1, rsp_id=1.
- Both valid continuously after reset, 4 ops -> grant order 0,1,0,1.
  - Requester 1: op=XOR, a=b=11111111 -> rsp_y=00000000.
  - Requester 0: op=NOT, a=00001111 -> rsp_y=11110000.
- Hold rsp_ready=0 for 5 cycles in RESP:
  - rsp_y and rsp_id stable, req_ready=00, busy=1.
  - A new req_valid is not accepted until 1 cycle after rsp_ready.
- Assert rst during EXEC:
  - Next cycle all outputs 0, FSM IDLE, no response emitted.
  - A subsequent tie is granted to req 0.
- Force done_cnt to wrap (CNT_W=2, 5 ops) -> done_cnt sequence 1,2,3,0,1.
